saber_cmd_sequencer: RTL and testbench

//  Host-side sequencer for ComputeCoreWrapper. Turns a valid/ready request stream (LOAD, CFG, EXEC) into the exact

---
 rtl/saber_ctrl_pkg.sv | 57 +++++
 rtl/saber_ctrl_word_pack.sv | 30 +++
 rtl/saber_cmd_sequencer.sv | 172 +++++++++++++++++
 tb/tb_saber_cmd_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/saber_ctrl_pkg.sv
// Purpose: shared encodings for the ComputeCoreWrapper command sequencer:
//   request kinds, control-word bit positions, FSM states and field widths.
package saber_ctrl_pkg;

  localparam int unsigned KIND_W   = 2;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned INS_W    = 5;
  localparam int unsigned OP_W     = 10;
  localparam int unsigned CMD_W    = INS_W + 3 * OP_W;  // 35
  localparam int unsigned WORD_W   = 64;
  localparam int unsigned HALF_W   = 32;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned STATUS_W = 32;
  localparam int unsigned CNT_W    = 32;

  // Control-word bit positions
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned WEA_BIT  = 10;
  localparam int unsigned CMD_LSB  = 11;
  localparam int unsigned WE0_BIT  = 46;
  localparam int unsigned WE1_BIT  = 47;

  typedef enum logic [KIND_W-1:0] {
    KIND_LOAD = 2'd0,
    KIND_CFG  = 2'd1,
    KIND_EXEC = 2'd2,
    KIND_RSVD = 2'd3
  } req_kind_e;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_CFG   = 4'd2,
    ST_GAP   = 4'd3,
    ST_CLR   = 4'd4,
    ST_ISSUE = 4'd5,
    ST_WAIT  = 4'd6,
    ST_ACK   = 4'd7,
    ST_RESP  = 4'd8
  } state_e;

  // Fields that make up one control word before packing
  typedef struct packed {
    logic              we1;
    logic              we0;
    logic [CMD_W-1:0]  cmd;
    logic              wea;
    logic [ADDR_W-1:0] addr;
  } ctrl_fields_t;

  // Saturating increment of the WAIT counter
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] limit);
    return (cnt >= limit) ? limit : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/saber_ctrl_word_pack.sv
// Purpose: combinational packer of control fields into the wrapper's 64-bit
//   control word, split into high/low halves.
// Ports:
//   fields_i       in   control fields {we1, we0, cmd, wea, addr}
//   ctrl_high_c_o  out  control[63:32]
//   ctrl_low_c_o   out  control[31:0]
module saber_ctrl_word_pack
  import saber_ctrl_pkg::*;
(
  input  ctrl_fields_t      fields_i,
  output logic [HALF_W-1:0] ctrl_high_c_o,
  output logic [HALF_W-1:0] ctrl_low_c_o
);

  logic [WORD_W-1:0] word_c;

  // Place each field at its fixed bit position; unused bits stay 0
  always_comb begin
    word_c                       = '0;
    word_c[ADDR_LSB +: ADDR_W]   = fields_i.addr;
    word_c[WEA_BIT]              = fields_i.wea;
    word_c[CMD_LSB +: CMD_W]     = fields_i.cmd;
    word_c[WE0_BIT]              = fields_i.we0;
    word_c[WE1_BIT]              = fields_i.we1;
  end

  assign ctrl_high_c_o = word_c[WORD_W-1:HALF_W];
  assign ctrl_low_c_o  = word_c[HALF_W-1:0];

endmodule

// File: rtl/saber_cmd_sequencer.sv
// Purpose: host-side sequencer for ComputeCoreWrapper. Converts LOAD/CFG/EXEC
//   requests into the exact cycle sequence of control and data words, waits on
//   status for EXEC, and reports completion, timeout and WAIT latency.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_kind/addr/arg        request payload
//   control_{high,low}_word  wrapper control word
//   dina_ext_{high,low}_word wrapper data word (nonzero only during LOAD)
//   status                   wrapper status, nonzero = done
//   rsp_valid/err/cycles     one-cycle completion report
//   busy                     sequencer not idle
module saber_cmd_sequencer
  import saber_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned SETTLE_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KIND_W-1:0]   req_kind,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_arg,
  output logic [HALF_W-1:0]   control_low_word,
  output logic [HALF_W-1:0]   control_high_word,
  output logic [HALF_W-1:0]   dina_ext_low_word,
  output logic [HALF_W-1:0]   dina_ext_high_word,
  input  logic [STATUS_W-1:0] status,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [CNT_W-1:0]    rsp_cycles,
  output logic                busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LIM  = CNT_W'(SETTLE_CYCLES);

  state_e            state_q, state_d;
  req_kind_e         kind_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] arg_q;
  logic [CNT_W-1:0]  cnt_q, cnt_inc_c;
  logic              err_q;

  logic              accept_c, done_c, timeout_c;
  ctrl_fields_t      fields_d;
  logic [HALF_W-1:0] ctrl_high_c, ctrl_low_c;
  logic [DATA_W-1:0] dina_d;

  logic              req_ready_q, busy_q, rsp_valid_q, rsp_err_q;
  logic [HALF_W-1:0] ctrl_high_q, ctrl_low_q, dina_high_q, dina_low_q;
  logic [CNT_W-1:0]  rsp_cycles_q;

  assign accept_c  = (state_q == ST_IDLE) && req_valid;
  assign cnt_inc_c = cnt_step(cnt_q, TIMEOUT_LIM);
  // Status is only trusted once the settle window has elapsed
  assign done_c    = (cnt_q >= SETTLE_LIM) && (status != '0);
  assign timeout_c = (cnt_inc_c == TIMEOUT_LIM);

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          unique case (req_kind_e'(req_kind))
            KIND_LOAD: state_d = ST_LOAD;
            KIND_CFG:  state_d = ST_CFG;
            KIND_EXEC: state_d = ST_CLR;
            default:   state_d = ST_RESP;
          endcase
        end
      end
      ST_LOAD:  state_d = ST_RESP;
      ST_CFG:   state_d = ST_GAP;
      ST_GAP:   state_d = ST_RESP;
      ST_CLR:   state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (done_c || timeout_c) state_d = ST_ACK;
      ST_ACK:   state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Drive word for the current state; registered on the next edge
  always_comb begin
    fields_d = '0;
    dina_d   = '0;
    unique case (state_q)
      ST_LOAD: begin
        fields_d.wea  = 1'b1;
        fields_d.addr = addr_q;
        dina_d        = arg_q;
      end
      ST_CFG: begin
        fields_d.we1 = 1'b1;
        fields_d.cmd = arg_q[CMD_W-1:0];
      end
      ST_CLR, ST_ACK: fields_d.we0 = 1'b1;
      ST_ISSUE: begin
        fields_d.we0 = 1'b1;
        fields_d.cmd = arg_q[CMD_W-1:0];
      end
      default: ;
    endcase
  end

  saber_ctrl_word_pack u_pack (
    .fields_i      (fields_d),
    .ctrl_high_c_o (ctrl_high_c),
    .ctrl_low_c_o  (ctrl_low_c)
  );

  // State, captured request, WAIT counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      kind_q       <= KIND_LOAD;
      addr_q       <= '0;
      arg_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      ctrl_high_q  <= '0;
      ctrl_low_q   <= '0;
      dina_high_q  <= '0;
      dina_low_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_cycles_q <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      ctrl_high_q <= ctrl_high_c;
      ctrl_low_q  <= ctrl_low_c;
      dina_high_q <= dina_d[DATA_W-1:HALF_W];
      dina_low_q  <= dina_d[HALF_W-1:0];

      rsp_valid_q  <= (state_q == ST_RESP);
      rsp_err_q    <= (state_q == ST_RESP) && err_q;
      rsp_cycles_q <= ((state_q == ST_RESP) && (kind_q == KIND_EXEC)) ? cnt_q : '0;

      if (accept_c) begin
        kind_q <= req_kind_e'(req_kind);
        addr_q <= req_addr;
        arg_q  <= req_arg;
        cnt_q  <= '0;
        err_q  <= (req_kind_e'(req_kind) == KIND_RSVD);
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_inc_c;
        // Completion seen on the timeout cycle still counts as success
        if (timeout_c && !done_c) err_q <= 1'b1;
      end
    end
  end

  assign req_ready          = req_ready_q;
  assign busy               = busy_q;
  assign control_high_word  = ctrl_high_q;
  assign control_low_word   = ctrl_low_q;
  assign dina_ext_high_word = dina_high_q;
  assign dina_ext_low_word  = dina_low_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_err            = rsp_err_q;
  assign rsp_cycles         = rsp_cycles_q;

endmodule

// File: tb/tb_saber_cmd_sequencer.sv
// Purpose: directed bench for saber_cmd_sequencer. Expected per-cycle output
//   snapshots are queued when a request is driven and compared one per clock.
module tb_saber_cmd_sequencer;

  localparam int unsigned TO     = 64;
  localparam int unsigned SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [9:0]  req_addr;
  logic [63:0] req_arg;
  logic [31:0] control_low_word, control_high_word;
  logic [31:0] dina_ext_low_word, dina_ext_high_word;
  logic [31:0] status;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_cycles;

  always #5 clk = ~clk;

  saber_cmd_sequencer #(.TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(SETTLE)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_kind           (req_kind),
    .req_addr           (req_addr),
    .req_arg            (req_arg),
    .control_low_word   (control_low_word),
    .control_high_word  (control_high_word),
    .dina_ext_low_word  (dina_ext_low_word),
    .dina_ext_high_word (dina_ext_high_word),
    .status             (status),
    .rsp_valid          (rsp_valid),
    .rsp_err            (rsp_err),
    .rsp_cycles         (rsp_cycles),
    .busy               (busy)
  );

  typedef struct packed {
    logic [63:0] word;
    logic [63:0] dina;
    logic        rv;
    logic        err;
    logic [31:0] cyc;
    logic        ready;
    logic        busy;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [63:0] W_IDLE = 64'h0;
  localparam logic [63:0] W_WE0  = {32'h0000_4000, 32'h0};

  task automatic push(input logic [63:0] w, input logic [63:0] d, input logic rv,
                      input logic e, input logic [31:0] c, input logic rdy, input logic b);
    obs_t o;
    o.word = w; o.dina = d; o.rv = rv; o.err = e; o.cyc = c; o.ready = rdy; o.busy = b;
    exp_q.push_back(o);
  endtask

  task automatic push_busy(input int n);
    for (int i = 0; i < n; i++) push(W_IDLE, 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic push_ready();
    push(W_IDLE, 64'h0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic push_rsp(input logic e, input logic [31:0] c);
    push(W_IDLE, 64'h0, 1'b1, e, c, 1'b1, 1'b0);
  endtask

  // Control word as laid out on the wrapper interface
  function automatic logic [63:0] cw(input logic we1, input logic we0, input logic [34:0] cmd,
                                     input logic wea, input logic [9:0] addr);
    logic [63:0] w;
    w = 64'h0;
    w[9:0] = addr; w[10] = wea; w[45:11] = cmd; w[46] = we0; w[47] = we1;
    return w;
  endfunction

  task automatic drive_req(input logic [1:0] k, input logic [9:0] a, input logic [63:0] arg);
    req_valid = 1'b1; req_kind = k; req_addr = a; req_arg = arg;
  endtask

  // One clock: apply status/rst, sample after the edge, compare against the queue head
  task automatic cycle(input logic [31:0] st, input logic r, input string tag);
    obs_t obs, e;
    status = st;
    rst    = r;
    @(posedge clk);
    #1;
    obs.word  = {control_high_word, control_low_word};
    obs.dina  = {dina_ext_high_word, dina_ext_low_word};
    obs.rv    = rsp_valid;
    obs.err   = rsp_err;
    obs.cyc   = rsp_cycles;
    obs.ready = req_ready;
    obs.busy  = busy;
    req_valid = 1'b0;
    req_kind  = 2'($urandom);
    req_addr  = 10'($urandom);
    req_arg   = {$urandom, $urandom};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic drain(input logic [31:0] st, input string tag);
    while (exp_q.size() != 0) cycle(st, 1'b0, tag);
  endtask

  initial begin
    logic [63:0] exec_arg;
    logic [63:0] load_arg;
    int          n;

    rst = 1'b1; req_valid = 1'b0; req_kind = 2'd0; req_addr = '0; req_arg = '0; status = '0;

    // Reset state
    push_ready(); push_ready();
    cycle(0, 1'b1, "reset0");
    cycle(0, 1'b1, "reset1");

    // LOAD addr 5
    drive_req(2'd0, 10'd5, 64'h83063bbf4ab6f1e9);
    push_busy(1);
    push({32'h0, 32'h0000_0405}, 64'h83063bbf4ab6f1e9, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push_rsp(1'b0, 32'd0);
    push_ready();
    drain(0, "load5");

    // LOAD at the top address
    load_arg = 64'hFFFF_0000_1234_ABCD;
    drive_req(2'd0, 10'd1023, load_arg);
    push_busy(1);
    push({32'h0, 32'h0000_07FF}, load_arg, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push_rsp(1'b0, 32'd0);
    drain(0, "load1023");

    // CFG {0,32,32}
    drive_req(2'd1, 10'd0, {29'd0, 3'd0, 16'd32, 16'd32});
    push_busy(1);
    push({32'h0000_8001, 32'h0001_0000}, 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push_busy(1);
    push_rsp(1'b0, 32'd0);
    push_ready();
    drain(0, "cfg");

    // EXEC, status rises on the 10th WAIT cycle (edge index 12 after accept)
    exec_arg = {29'd0, 10'd124, 10'd0, 10'd124, 5'd1};
    drive_req(2'd2, 10'd0, exec_arg);
    push_busy(1);
    push(W_WE0, 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push({32'h0000_47C0, 32'h007C_0800}, 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push_busy(10);
    push(W_WE0, 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push_rsp(1'b0, 32'd10);
    push_ready();
    n = exp_q.size();
    for (int i = 0; i < n; i++) cycle((i == 12) ? 32'd1 : 32'd0, 1'b0, "exec10");

    // EXEC timeout with status stuck at 0
    exec_arg = {29'd0, 10'd1023, 10'd9, 10'd7, 5'd3};
    drive_req(2'd2, 10'd0, exec_arg);
    push_busy(1);
    push(W_WE0, 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push(cw(1'b0, 1'b1, exec_arg[34:0], 1'b0, 10'd0), 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push_busy(TO);
    push(W_WE0, 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push_rsp(1'b1, 32'(TO));
    push_ready();
    drain(0, "exec_timeout");

    // LOAD accepted right after the timeout
    drive_req(2'd0, 10'd3, 64'h0000_0001_0000_0002);
    push_busy(1);
    push({32'h0, 32'h0000_0403}, 64'h0000_0001_0000_0002, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push_rsp(1'b0, 32'd0);
    drain(0, "load_after_to");

    // Status already high at ISSUE: settle window ignores it for 2 cycles
    exec_arg = {29'd0, 10'd1, 10'd2, 10'd3, 5'd4};
    drive_req(2'd2, 10'd0, exec_arg);
    push_busy(1);
    push(W_WE0, 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push(cw(1'b0, 1'b1, exec_arg[34:0], 1'b0, 10'd0), 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push_busy(3);
    push(W_WE0, 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push_rsp(1'b0, 32'd3);
    push_ready();
    drain(1, "exec_settle");

    // Reserved kind: error response after one cycle, no drive
    drive_req(2'd3, 10'd77, 64'hDEAD_BEEF_DEAD_BEEF);
    push_busy(1);
    push_rsp(1'b1, 32'd0);
    push_ready();
    drain(0, "reserved");

    // Reset during WAIT
    exec_arg = {29'd0, 10'd5, 10'd6, 10'd7, 5'd2};
    drive_req(2'd2, 10'd0, exec_arg);
    push_busy(1);
    push(W_WE0, 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push(cw(1'b0, 1'b1, exec_arg[34:0], 1'b0, 10'd0), 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push_busy(1);
    push_ready();
    push_ready();
    push_ready();
    n = exp_q.size();
    for (int i = 0; i < n; i++) cycle(0, (i == 4) ? 1'b1 : 1'b0, "rst_wait");

    // Recovery after reset
    drive_req(2'd0, 10'd8, 64'h1111_2222_3333_4444);
    push_busy(1);
    push({32'h0, 32'h0000_0408}, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    push_rsp(1'b0, 32'd0);
    push_ready();
    drain(0, "load_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
